io_uart_tx: RTL and testbench
=============================

// Module: io_uart_tx
// PURPOSE
//  Receiving end of the CPU output port: captures each io_write/io_data pulse into a word FIFO.
//  - Serialises every 64-bit word onto a UART 8N1 line, txd.
//  - Sits beside cpu and takes its io_write/io_data directly.
//  - No backpressure toward the CPU (the CPU cannot stall): when the FIFO is full the word is dropped and flagged.
// PARAMETERS
//  CLK_DIV     16  clk cycles per UART bit; legal range >= 2
//  FIFO_DEPTH  4   word FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  io_write   in   1   single-cycle strobe from CPU store to 0xFF
//  io_data    in   64  word to send; valid when io_write=1
//  clear_ovf  in   1   pulse: clears overflow
//  txd        out  1   UART serial out; idle high
//  busy       out  1   1 when FIFO non-empty or frame in progress
//  fifo_full  out  1   1 when FIFO count == FIFO_DEPTH
//  overflow   out  1   sticky: a write was dropped
// BEHAVIOUR
//  - Reset values: txd=1, busy=0, fifo_full=0, overflow=0, FIFO empty, FSM=IDLE, all counters=0.
//    Reset mid-frame aborts the frame; txd=1 from the next edge.
//  - FIFO write: on the edge where io_write=1, accept if count<FIFO_DEPTH or a pop occurs on the same edge.
//    Otherwise drop the word and set overflow=1.
//  - FIFO pointers wrap modulo FIFO_DEPTH. count is registered.
//  - overflow: set wins over clear_ovf on the same edge.
//  - Pop: on the edge where FSM=IDLE and count>0, head word -> shift_word, byte_idx=0, FSM -> START.
//  - Latency: io_write sampled at edge N with FSM idle -> pop at N+1 -> txd low after edge N+2.
//  - FSM states:
//    IDLE: txd=1; go to START on pop.
//    START: txd=0 for CLK_DIV cycles; then DATA with bit_idx=0.
//    DATA: txd=cur_byte[bit_idx], LSB first, CLK_DIV cycles per bit; after bit 7 go to STOP.
//    STOP: txd=1 for CLK_DIV cycles. Then:
//      if more bytes remain, go to START directly (no idle gap);
//      else go to IDLE. A new pop can occur on the next edge.
//  - txd is driven from a register (glitch-free).
//  - Byte order (raw mode): byte 0 = io_data[7:0] through byte 7 = io_data[63:56].
//    Word time = 80*CLK_DIV cycles.
//  - baud_cnt counts 0..CLK_DIV-1 and resets at each bit boundary.
//  - busy = (count!=0) | (FSM!=IDLE), combinational from registers.
//  - The FIFO keeps accepting writes during transmission. FIFO order is strictly preserved.
// CONFIGURATION
//  IO_UART_HEX_EN defined: each word is sent as 17 ASCII characters.
//    - 16 uppercase hex digits, most-significant nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
//    - Then 0x0A (newline).
//    - Same 8N1 framing per character. Word time = 170*CLK_DIV.
//  IO_UART_HEX_EN undefined: raw mode, 8 binary bytes LSB-byte first. No hex encoder logic is present.
// TESTING (CLK_DIV=4, FIFO_DEPTH=4 unless noted)
//  1 Raw word 0x0000_0000_0000_0041:
//    -> txd low after edge 2 for 4 cycles; data bits 1,0,0,0,0,0,1,0; high 4 cycles; then 7 frames of 0x00.
//    -> busy=0 exactly 320 cycles after the first pop.
//  2 Six back-to-back io_write, 0x1..0x6, FSM idle:
//    -> 0x1-0x5 transmitted in order.
//    -> 0x6 dropped; overflow=1 after edge 5; fifo_full=1 after edge 4.
//  3 clear_ovf and a dropped write on the same edge -> overflow stays 1.
//    A following lone clear_ovf -> overflow=0.
//  4 rst asserted mid-DATA of byte 3 -> txd=1, busy=0, fifo_full=0 next edge.
//    A new write after reset -> fresh frame starting at byte 0.
//  5 IO_UART_HEX_EN, word 0x0123_4567_89AB_CDEF -> UART decoder receives "0123456789ABCDEF\n".
//    busy drops 680 cycles after the pop.
//  6 CLK_DIV=7, word 0xA5 -> every bit period measured as exactly 7 cycles; stop bit high 7 cycles.

Source files
------------

// File: rtl/io_uart_tx.sv
// io_uart_tx: CPU output port. It captures io_write/io_data strobes into a small
// word FIFO and serialises each 64-bit word on an 8N1 UART line (txd).
// The CPU is never stalled. A write to a full FIFO is dropped and latched in the
// sticky overflow flag.
// Build option IO_UART_HEX_EN: send each word as 16 uppercase ASCII hex digits,
// most-significant nibble first, followed by a newline. Without it, the eight raw
// bytes are sent with the least-significant byte first.
module io_uart_tx #(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_write,
   input  logic [63:0] io_data,
   input  logic        clear_ovf,
   output logic        txd,
   output logic        busy,
   output logic        fifo_full,
   output logic        overflow
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef IO_UART_HEX_EN
   localparam int LAST_CHAR = 16;
`else
   localparam int LAST_CHAR = 7;
`endif

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [4:0]        CHAR_LAST = 5'(LAST_CHAR);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

`ifdef IO_UART_HEX_EN
   // ASCII code of one hex digit ('0'-'9', 'A'-'F').
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      logic [7:0] code;
      if (nib < 4'd10) begin
         code = 8'h30 + {4'h0, nib};
      end else begin
         code = 8'h37 + {4'h0, nib};
      end
      return code;
   endfunction
`endif

   logic [63:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [4:0]        char_idx_q, char_idx_d;
   logic [63:0]       shift_word_q, shift_word_d;
   logic              txd_q, txd_d;

   logic              pop_s;
   logic              push_s;
   logic              drop_s;
   logic [7:0]        cur_byte_s;

   // FIFO control. A pop on the same edge frees a slot, so a write to a full FIFO is still accepted then.
   always_comb begin
      pop_s      = (state_q == ST_IDLE) && (count_q != {CNT_W{1'b0}});
      push_s     = io_write && ((count_q < CNT_FULL) || pop_s);
      drop_s     = io_write && !push_s;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      // A drop has priority over a clear on the same edge.
      if (drop_s) begin
         overflow_d = 1'b1;
      end else if (clear_ovf) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Select the character being sent. It is taken from the top nibble in hex mode and from the low byte in raw mode.
   always_comb begin
`ifdef IO_UART_HEX_EN
      if (char_idx_q == CHAR_LAST) begin
         cur_byte_s = 8'h0A;
      end else begin
         cur_byte_s = hex_ascii(shift_word_q[63:60]);
      end
`else
      cur_byte_s = shift_word_q[7:0];
`endif
   end

   // Framing FSM: next state, bit and baud counters, and the next txd level.
   always_comb begin
      state_d      = state_q;
      baud_d       = baud_q;
      bit_idx_d    = bit_idx_q;
      char_idx_d   = char_idx_q;
      shift_word_d = shift_word_q;
      txd_d        = 1'b1;
      case (state_q)
         ST_IDLE: begin
            txd_d = 1'b1;
            if (pop_s) begin
               state_d      = ST_START;
               baud_d       = {BAUD_W{1'b0}};
               char_idx_d   = 5'd0;
               shift_word_d = mem_q[rd_ptr_q];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            txd_d = 1'b0;
            if (baud_q == BAUD_LAST) begin
               baud_d    = {BAUD_W{1'b0}};
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         ST_DATA: begin
            txd_d = cur_byte_s[bit_idx_q];
            if (baud_q == BAUD_LAST) begin
               baud_d = {BAUD_W{1'b0}};
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         ST_STOP: begin
            txd_d = 1'b1;
            if (baud_q == BAUD_LAST) begin
               baud_d = {BAUD_W{1'b0}};
               if (char_idx_q == CHAR_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  // Move straight to the next start bit with no idle gap.
                  char_idx_d = char_idx_q + 5'd1;
                  state_d    = ST_START;
`ifdef IO_UART_HEX_EN
                  shift_word_d = {shift_word_q[59:0], 4'h0};
`else
                  shift_word_d = {8'h00, shift_word_q[63:8]};
`endif
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         default: begin
            txd_d   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, pointer and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         count_q      <= {CNT_W{1'b0}};
         overflow_q   <= 1'b0;
         state_q      <= ST_IDLE;
         baud_q       <= {BAUD_W{1'b0}};
         bit_idx_q    <= 3'd0;
         char_idx_q   <= 5'd0;
         shift_word_q <= 64'd0;
         txd_q        <= 1'b1;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_idx_q    <= bit_idx_d;
         char_idx_q   <= char_idx_d;
         shift_word_q <= shift_word_d;
         txd_q        <= txd_d;
      end
   end

   // FIFO storage. It holds no control state, so it is not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= io_data;
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

   assign txd       = txd_q;
   assign overflow  = overflow_q;
   assign fifo_full = (count_q == CNT_FULL);
   assign busy      = (count_q != {CNT_W{1'b0}}) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx. A UART decoder pops expected characters from a scoreboard queue.
// The second instance, which has CLK_DIV=7, is used to measure bit periods.
module tb_io_uart_tx;

   localparam int DIV = 4;
`ifdef IO_UART_HEX_EN
   localparam int WORD_CYC = 170 * DIV;
`else
   localparam int WORD_CYC = 80 * DIV;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        io_write = 1'b0;
   logic [63:0] io_data = 64'd0;
   logic        clear_ovf = 1'b0;
   logic        txd, busy, fifo_full, overflow;

   logic        io_write7 = 1'b0;
   logic [63:0] io_data7 = 64'd0;
   logic        clear_ovf7 = 1'b0;
   logic        txd7, busy7, full7, ovf7;

   int          total = 0;
   int          passed = 0;
   int          failed = 0;
   logic        dec_en = 1'b1;
   logic [7:0]  exp_q[$];

   io_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .io_write(io_write), .io_data(io_data), .clear_ovf(clear_ovf),
      .txd(txd), .busy(busy), .fifo_full(fifo_full), .overflow(overflow));

   io_uart_tx #(.CLK_DIV(7), .FIFO_DEPTH(4)) dut7 (
      .clk(clk), .rst(rst), .io_write(io_write7), .io_data(io_data7), .clear_ovf(clear_ovf7),
      .txd(txd7), .busy(busy7), .fifo_full(full7), .overflow(ovf7));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Push the characters the line should carry for one accepted word.
   task automatic push_word(input logic [63:0] w);
`ifdef IO_UART_HEX_EN
      logic [3:0] nib;
      for (int i = 0; i < 16; i++) begin
         nib = w[63 - 4*i -: 4];
         exp_q.push_back((nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib}));
      end
      exp_q.push_back(8'h0A);
`else
      for (int i = 0; i < 8; i++) exp_q.push_back(w[8*i +: 8]);
`endif
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   // UART decoder: samples each bit in the middle of its period and compares the result with the scoreboard.
   initial begin : decoder
      logic       prev;
      logic [7:0] rx;
      logic [7:0] exp;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (dec_en && !rst && prev && txd === 1'b0) begin
            repeat (DIV/2) @(negedge clk);
            check("start_mid", {63'd0, txd}, 64'd0);
            for (int b = 0; b < 8; b++) begin
               repeat (DIV) @(negedge clk);
               rx[b] = txd;
            end
            repeat (DIV) @(negedge clk);
            check("stop_bit", {63'd0, txd}, 64'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_char", {56'd0, rx}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               exp = exp_q.pop_front();
               check("rx_char", {56'd0, rx}, {56'd0, exp});
            end
            prev = txd;
         end else begin
            prev = txd;
         end
      end
   end

   initial begin : stim
      logic       s7 [0:70];
      logic [7:0] ch7;
      logic       e;
      int         m;
      int         n;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_txd", {63'd0, txd}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_full", {63'd0, fifo_full}, 64'd0);
      check("rst_ovf", {63'd0, overflow}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Test 1: latency of a single raw word and the exact time busy drops
      io_write = 1'b1; io_data = 64'h41; push_word(64'h41);
      @(negedge clk);                       // after edge 0
      io_write = 1'b0;
      check("t1_busy_e0", {63'd0, busy}, 64'd1);
      check("t1_txd_e0", {63'd0, txd}, 64'd1);
      @(negedge clk);                       // after edge 1 (pop)
      check("t1_txd_e1", {63'd0, txd}, 64'd1);
      @(negedge clk);                       // after edge 2
      check("t1_txd_e2", {63'd0, txd}, 64'd0);
      repeat (WORD_CYC - 2) @(negedge clk); // after edge WORD_CYC
      check("t1_busy_before", {63'd0, busy}, 64'd1);
      @(negedge clk);                       // after edge WORD_CYC+1
      check("t1_busy_after", {63'd0, busy}, 64'd0);
      repeat (4) @(negedge clk);

      // Test 2: six back-to-back writes; the sixth is dropped
      for (int i = 0; i < 6; i++) begin
         io_write = 1'b1; io_data = 64'(i + 1);
         if (i < 5) push_word(64'(i + 1));
         @(negedge clk);                    // after edge i
         check("t2_full", {63'd0, fifo_full}, {63'd0, (i >= 4)});
         check("t2_ovf", {63'd0, overflow}, {63'd0, (i >= 5)});
      end
      // Test 3: a clear on the same edge as a drop leaves the flag set
      io_data = 64'h7; clear_ovf = 1'b1;
      @(negedge clk);
      check("t3_ovf_set_wins", {63'd0, overflow}, 64'd1);
      io_write = 1'b0;
      @(negedge clk);
      check("t3_ovf_clear", {63'd0, overflow}, 64'd0);
      clear_ovf = 1'b0;
      wait_idle(6 * WORD_CYC);
      repeat (8) @(negedge clk);

      // Test 4: reset during the data bits of byte 3
      dec_en = 1'b0;
      io_write = 1'b1; io_data = 64'h1122_3344_5566_7788;
      @(negedge clk);
      io_write = 1'b0;
      repeat (135) @(negedge clk);
      check("t4_busy_pre", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t4_txd", {63'd0, txd}, 64'd1);
      check("t4_busy", {63'd0, busy}, 64'd0);
      check("t4_full", {63'd0, fifo_full}, 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      dec_en = 1'b1;
      io_write = 1'b1; io_data = 64'hCAFE_F00D_0123_ABCD; push_word(64'hCAFE_F00D_0123_ABCD);
      @(negedge clk);
      io_write = 1'b0;
      wait_idle(2 * WORD_CYC);
      repeat (8) @(negedge clk);

      // Test 6: bit period measurement at CLK_DIV=7
`ifdef IO_UART_HEX_EN
      ch7 = 8'h30;
`else
      ch7 = 8'hA5;
`endif
      io_write7 = 1'b1; io_data7 = 64'hA5;
      @(negedge clk);
      io_write7 = 1'b0;
      n = 0;
      while (txd7 !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_start_seen", {63'd0, txd7}, 64'd0);
      for (int k = 0; k <= 70; k++) begin
         s7[k] = txd7;
         @(negedge clk);
      end
      for (int b = 0; b < 10; b++) begin
         e = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : ch7[b-1]);
         m = 0;
         for (int k = 0; k < 7; k++) if (s7[b*7 + k] === e) m++;
         check($sformatf("t6_bit_period_%0d", b), 64'(m), 64'd7);
      end
      check("t6_stop_end", {63'd0, s7[70]}, 64'd0);
      n = 0;
      while (busy7 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t6_idle", {63'd0, busy7}, 64'd0);
      check("t6_flags", {62'd0, full7, ovf7}, 64'd0);

      // All expected characters must have been received.
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
